// File: rtl/decode_stage.sv
// decode_stage -- registered instruction-decode stage for the SIMD pipeline.
//
// Sits between fetch and register read. Each accepted instruction is decoded
// from its 4-bit opcode and held as a control bundle in one pipeline register,
// with valid/ready handshaking on both sides and a flush input.
//
// Optional feature (compile-time macro DECODE_SCOREBOARD_EN):
//   When defined, one busy counter is kept per register. A load leaving the
//   stage marks its destination busy for LOAD_LAT cycles. Issue stalls while
//   the incoming instruction's destination is busy, or is the destination of
//   a load currently held in the stage. When undefined, there is no stall
//   logic and LOAD_LAT has no effect.
//
// Parameters:
//   N        instruction width (>= 4 + REG_W + 1)
//   REG_W    register-address width (>= 2)
//   REG_SIZE immediate output width (field zero-extended or truncated)
//   LOAD_LAT cycles a load destination stays busy after leaving (>= 1)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_instr     incoming instruction; in_ready = accepted this cycle
//   flush                 drop the held and the incoming instruction
//   out_valid/out_ready   outgoing control bundle handshake
//   mem_write, write_reg_from, reg_to_write, immediate, write_mem_from,
//   reg_write_en_sc, reg_write_en_vec, pc_write_en, overwrite_nz, alu_opcode
//                         decoded control bundle (held while stalled)
module decode_stage #(
  parameter int N        = 24,
  parameter int REG_W    = 4,
  parameter int REG_SIZE = 16,
  parameter int LOAD_LAT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [N-1:0]        in_instr,
  output logic                in_ready,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                mem_write,
  output logic [1:0]          write_reg_from,
  output logic [REG_W-1:0]    reg_to_write,
  output logic [REG_SIZE-1:0] immediate,
  output logic                write_mem_from,
  output logic                reg_write_en_sc,
  output logic                reg_write_en_vec,
  output logic [2:0]          pc_write_en,
  output logic                overwrite_nz,
  output logic [2:0]          alu_opcode
);

  localparam int IMM_W = N - 4 - REG_W;

  typedef struct packed {
    logic                mem_write;
    logic [1:0]          write_reg_from;
    logic [REG_W-1:0]    reg_to_write;
    logic [REG_SIZE-1:0] immediate;
    logic                write_mem_from;
    logic                reg_write_en_sc;
    logic                reg_write_en_vec;
    logic [2:0]          pc_write_en;
    logic                overwrite_nz;
    logic [2:0]          alu_opcode;
    logic                is_load;
  } bundle_t;

  // Zero-extend or truncate the immediate field to REG_SIZE bits.
  function automatic logic [REG_SIZE-1:0] imm_fit(input logic [IMM_W-1:0] imm);
    logic [REG_SIZE+IMM_W-1:0] wide;
    wide = {{REG_SIZE{1'b0}}, imm};
    return wide[REG_SIZE-1:0];
  endfunction

  function automatic bundle_t decode(input logic [N-1:0] instr);
    bundle_t          b;
    logic [3:0]       op;
    logic [REG_W-1:0] rd;
    logic             regwe;
    logic             rd_hi;
    op    = instr[N-1 -: 4];
    rd    = instr[N-5 -: REG_W];
    regwe = ~op[3] | ((op[3:2] == 2'b11) & op[0]);
    // Registers whose top two address bits are zero live in the vector file.
    rd_hi = |rd[REG_W-1 -: 2];
    b.mem_write         = (op == 4'b1100);
    b.write_reg_from[0] = (op == 4'b0000) ? 1'b0 : ~op[3];
    b.write_reg_from[1] = (op[3:2] == 2'b10) | (op == 4'b0000);
    b.reg_to_write      = rd;
    b.immediate         = imm_fit(instr[IMM_W-1:0]);
    b.write_mem_from    = (op[3:1] == 3'b110);
    b.reg_write_en_sc   = regwe & rd_hi;
    b.reg_write_en_vec  = regwe & ~rd_hi;
    b.pc_write_en       = {op == 4'b1001, op == 4'b1000, op == 4'b1111};
    b.overwrite_nz      = ~op[3] & |op[2:0];
    b.alu_opcode        = op[2:0];
    b.is_load           = (op == 4'b1101) | (op == 4'b1111);
    return b;
  endfunction

  bundle_t bundle_p1;
  logic    vld_p1;
  logic    hazard;
  logic    xfer_in;

  assign in_ready = (~vld_p1 | out_ready) & ~hazard & ~flush;
  assign xfer_in  = in_valid & in_ready;

`ifdef DECODE_SCOREBOARD_EN
  localparam int BUSY_W = $clog2(LOAD_LAT + 1);

  logic [BUSY_W-1:0] busy [2**REG_W];
  logic [REG_W-1:0]  rd_in;
  logic              load_out;

  assign rd_in    = in_instr[N-5 -: REG_W];
  // Flush cancels the outgoing transfer, so a flushed load never marks busy.
  assign load_out = vld_p1 & out_ready & ~flush & bundle_p1.is_load;
  assign hazard   = in_valid & ((busy[rd_in] != '0) |
                    (vld_p1 & bundle_p1.is_load & (bundle_p1.reg_to_write == rd_in)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_W; i++) busy[i] <= '0;
    end else begin
      for (int i = 0; i < 2**REG_W; i++) begin
        if (load_out && (bundle_p1.reg_to_write == REG_W'(i)))
          busy[i] <= BUSY_W'(LOAD_LAT);
        else if (busy[i] != '0)
          busy[i] <= busy[i] - 1'b1;
      end
    end
  end
`else
  logic unused_cfg;
  assign hazard     = 1'b0;
  assign unused_cfg = (LOAD_LAT != 0) ^ bundle_p1.is_load;
`endif

  // ---- stage p1: decoded control bundle register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
    end else begin
      if (flush)
        vld_p1 <= 1'b0;
      else if (xfer_in)
        vld_p1 <= 1'b1;
      else if (out_ready)
        vld_p1 <= 1'b0;
      if (xfer_in)
        bundle_p1 <= decode(in_instr);
    end
  end

  assign out_valid        = vld_p1;
  assign mem_write        = bundle_p1.mem_write;
  assign write_reg_from   = bundle_p1.write_reg_from;
  assign reg_to_write     = bundle_p1.reg_to_write;
  assign immediate        = bundle_p1.immediate;
  assign write_mem_from   = bundle_p1.write_mem_from;
  assign reg_write_en_sc  = bundle_p1.reg_write_en_sc;
  assign reg_write_en_vec = bundle_p1.reg_write_en_vec;
  assign pc_write_en      = bundle_p1.pc_write_en;
  assign overwrite_nz     = bundle_p1.overwrite_nz;
  assign alu_opcode       = bundle_p1.alu_opcode;

endmodule
